// File: rtl/hazard_scoreboard_pkg.sv
// CPU-wide pipeline timing encodings shared by the operand-use decoders and the
// hazard scoreboard: Tuse/Tnew stage numbers and forwarding-select values.
package hazard_scoreboard_pkg;

  localparam logic [1:0] TUSE_ID  = 2'd0;
  localparam logic [1:0] TUSE_EX  = 2'd1;
  localparam logic [1:0] TUSE_MEM = 2'd2;

  // Forward select k means "take the value held in tracked stage k".
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_operand_check.sv
// Youngest-match search of one ID operand against the tracked stages, giving
// that operand's data stall and forwarding select.
module hazard_operand_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TNEW_W = 2,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic                     used,
  input  logic [REG_AW-1:0]        addr,
  input  logic [TNEW_W-1:0]        tuse,
  input  logic [STAGES*REG_AW-1:0] wr_flat,
  input  logic [STAGES*TNEW_W-1:0] tnew_flat,
  output logic                     data_stall,
  output logic [SEL_W-1:0]         sel
);

  logic              hit;
  logic [TNEW_W-1:0] hit_tnew;
  logic [SEL_W-1:0]  hit_stage;

  // Walk oldest to youngest so a younger match overwrites (shadows) older ones.
  always_comb begin
    hit       = 1'b0;
    hit_tnew  = '0;
    hit_stage = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (used && (addr != '0) && (wr_flat[(k-1)*REG_AW +: REG_AW] == addr)) begin
        hit       = 1'b1;
        hit_tnew  = tnew_flat[(k-1)*TNEW_W +: TNEW_W];
        hit_stage = SEL_W'(k);
      end
    end
  end

  assign data_stall = hit && (hit_tnew > tuse);
  assign sel        = (hit && (hit_tnew == '0)) ? hit_stage : SEL_W'(FWD_RF);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shift register of in-flight destinations with remaining
// Tnew, per-operand stall/forward decisions, and the mult/div busy countdown.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int TNEW_W     = 2,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic                         id_rs_used,
  input  logic [REG_AW-1:0]            id_rs_addr,
  input  logic [TNEW_W-1:0]            id_rs_tuse,
  input  logic                         id_rt_used,
  input  logic [REG_AW-1:0]            id_rt_addr,
  input  logic [TNEW_W-1:0]            id_rt_tuse,
  input  logic [REG_AW-1:0]            id_wr_addr,
  input  logic [TNEW_W-1:0]            id_tnew,
  input  logic                         id_md_start,
  input  logic                         id_md_div,
  input  logic                         id_md_access,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
  output logic                         md_busy
);

  localparam int SEL_W = $clog2(STAGES+1);
  localparam int CNT_W = $clog2(DIV_CYCLES+1);

  // Stage k lives at slice [(k-1)*W +: W]; stage 1 is the youngest.
  logic [STAGES*REG_AW-1:0] wr_q, wr_d;
  logic [STAGES*TNEW_W-1:0] tnew_q, tnew_d;
  logic [CNT_W-1:0]         md_cnt;
  logic                     rs_stall, rt_stall, md_stall, accept;
  logic [SEL_W-1:0]         rs_sel, rt_sel;

  hazard_operand_check #(
    .STAGES(STAGES), .TNEW_W(TNEW_W), .REG_AW(REG_AW), .SEL_W(SEL_W)
  ) u_rs_check (
    .used(id_rs_used), .addr(id_rs_addr), .tuse(id_rs_tuse),
    .wr_flat(wr_q), .tnew_flat(tnew_q), .data_stall(rs_stall), .sel(rs_sel)
  );

  hazard_operand_check #(
    .STAGES(STAGES), .TNEW_W(TNEW_W), .REG_AW(REG_AW), .SEL_W(SEL_W)
  ) u_rt_check (
    .used(id_rt_used), .addr(id_rt_addr), .tuse(id_rt_tuse),
    .wr_flat(wr_q), .tnew_flat(tnew_q), .data_stall(rt_stall), .sel(rt_sel)
  );

  assign md_busy    = (md_cnt != '0);
  assign md_stall   = (id_md_start | id_md_access) & md_busy;
  assign stall      = id_valid & (rs_stall | rt_stall | md_stall);
  assign accept     = id_valid & ~stall & ~flush;
  assign fwd_rs_sel = stall ? SEL_W'(FWD_RF) : rs_sel;
  assign fwd_rt_sel = stall ? SEL_W'(FWD_RF) : rt_sel;

  // Stages never stall, so every edge advances; unaccepted slots become bubbles.
  always_comb begin
    wr_d   = '0;
    tnew_d = '0;
    for (int k = 2; k <= STAGES; k++) begin
      wr_d[(k-1)*REG_AW +: REG_AW] = wr_q[(k-2)*REG_AW +: REG_AW];
      tnew_d[(k-1)*TNEW_W +: TNEW_W] =
        (tnew_q[(k-2)*TNEW_W +: TNEW_W] == '0) ? '0
                                               : tnew_q[(k-2)*TNEW_W +: TNEW_W] - TNEW_W'(1);
    end
    if (accept) begin
      wr_d[REG_AW-1:0]   = id_wr_addr;
      tnew_d[TNEW_W-1:0] = id_tnew;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      tnew_q <= '0;
      md_cnt <= '0;
    end else if (flush) begin
      wr_q   <= '0;
      tnew_q <= '0;
      md_cnt <= '0;
    end else begin
      wr_q   <= wr_d;
      tnew_q <= tnew_d;
      if (accept && id_md_start)
        md_cnt <= id_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-scenario tasks push the
// expected {stall, fwd_rs_sel, fwd_rt_sel, md_busy} per cycle and compare it.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid, id_rs_used, id_rt_used;
  logic [4:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic [1:0] id_rs_tuse, id_rt_tuse, id_tnew;
  logic       id_md_start, id_md_div, id_md_access, flush;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [5:0] obs;

  logic [5:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_used(id_rs_used), .id_rs_addr(id_rs_addr), .id_rs_tuse(id_rs_tuse),
    .id_rt_used(id_rt_used), .id_rt_addr(id_rt_addr), .id_rt_tuse(id_rt_tuse),
    .id_wr_addr(id_wr_addr), .id_tnew(id_tnew), .id_md_start(id_md_start),
    .id_md_div(id_md_div), .id_md_access(id_md_access), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  assign obs = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // driver tasks
  task automatic set_id(input logic v,
                        input logic rsu, input logic [4:0] rsa, input logic [1:0] rsq,
                        input logic rtu, input logic [4:0] rta, input logic [1:0] rtq,
                        input logic [4:0] wa, input logic [1:0] tn,
                        input logic ms, input logic md, input logic ma);
    id_valid = v;
    id_rs_used = rsu; id_rs_addr = rsa; id_rs_tuse = rsq;
    id_rt_used = rtu; id_rt_addr = rta; id_rt_tuse = rtq;
    id_wr_addr = wa; id_tnew = tn;
    id_md_start = ms; id_md_div = md; id_md_access = ma;
  endtask

  task automatic drain();
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (12) @(negedge clk);
  endtask

  // scenario tasks
  task automatic test_reset();
    logic [5:0] e;
    flush = 1'b0;
    set_id(1, 1, 8, 0, 1, 9, 0, 3, 2, 1, 0, 1);
    #2 reset = 1'b1;
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_state got %b expected %b", obs, e); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load_use();
    logic [5:0] e;
    drain();
    @(negedge clk);
    set_id(1, 1, 29, 1, 0, 0, 0, 8, 2, 0, 0, 0);   // lw $8
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL load_use_lw got %b expected %b", obs, e); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_id(1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // beq $8,$0
      exp_q.push_back((i < 3) ? 6'b1_00_00_0 : 6'b0_11_00_0);
      #1 e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use_beq cyc %0d got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_alu_forward();
    logic [5:0] e;
    drain();
    @(negedge clk);
    set_id(1, 1, 1, 1, 1, 2, 1, 9, 1, 0, 0, 0);    // addu $9
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL alu_producer got %b expected %b", obs, e); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_id(1, 1, 4, 1, 1, 9, 1, 11, 1, 0, 0, 0); // addu $11,$4,$9
      case (i)
        1:       exp_q.push_back(6'b0_00_00_0);
        2:       exp_q.push_back(6'b0_00_10_0);
        default: exp_q.push_back(6'b0_00_11_0);
      endcase
      #1 e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL alu_forward cyc %0d got %b expected %b", i, obs, e); end
    end
  endtask

  task automatic test_shadow();
    logic [5:0] e;
    drain();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_id(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      exp_q.push_back(6'b0);
      #1 e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL shadow_writer %0d got %b expected %b", i, obs, e); end
    end
    @(negedge clk);
    set_id(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(6'b0_00_00_0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL shadow_youngest got %b expected %b", obs, e); end
    @(negedge clk);
    set_id(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(6'b0_10_00_0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL shadow_stage2 got %b expected %b", obs, e); end
  endtask

  task automatic test_md(input logic is_div, input int busy_cycles);
    logic [5:0] e;
    drain();
    @(negedge clk);
    set_id(1, 1, 4, 1, 1, 5, 1, 0, 0, 1, is_div, 0);
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL md_start div=%0b got %b expected %b", is_div, obs, e); end
    for (int i = 1; i <= busy_cycles + 1; i++) begin
      @(negedge clk);
      set_id(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 1);  // mflo $8
      exp_q.push_back((i <= busy_cycles) ? 6'b1_00_00_1 : 6'b0);
      #1 e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL md_mflo div=%0b cyc %0d got %b expected %b", is_div, i, obs, e); end
    end
  endtask

  task automatic test_flush();
    logic [5:0] e;
    drain();
    @(negedge clk);
    set_id(1, 1, 4, 1, 1, 5, 1, 0, 0, 1, 1, 0);    // div
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_div got %b expected %b", obs, e); end
    @(negedge clk);
    set_id(1, 1, 29, 1, 0, 0, 0, 8, 2, 0, 0, 0);   // lw $8
    exp_q.push_back(6'b0_00_00_1);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_lw got %b expected %b", obs, e); end
    @(negedge clk);
    flush = 1'b1;
    set_id(1, 1, 8, 0, 0, 0, 0, 10, 0, 0, 0, 0);
    exp_q.push_back(6'b1_00_00_1);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_pre got %b expected %b", obs, e); end
    @(negedge clk);
    flush = 1'b0;
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_post got %b expected %b", obs, e); end
    @(negedge clk);
    flush = 1'b1;
    set_id(1, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0);   // would be accepted without flush
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_priority_pre got %b expected %b", obs, e); end
    @(negedge clk);
    flush = 1'b0;
    set_id(1, 1, 12, 0, 1, 10, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL flush_not_entered got %b expected %b", obs, e); end
  endtask

  task automatic test_reset_midstream();
    logic [5:0] e;
    drain();
    @(negedge clk);
    set_id(1, 1, 4, 1, 1, 5, 1, 0, 0, 1, 1, 0);    // div
    #1;
    @(negedge clk);
    set_id(1, 1, 29, 1, 0, 0, 0, 8, 2, 0, 0, 0);   // lw $8
    #1;
    @(negedge clk);
    set_id(1, 1, 8, 0, 1, 8, 0, 3, 1, 0, 0, 1);
    exp_q.push_back(6'b1_00_00_1);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL midreset_pre got %b expected %b", obs, e); end
    #1 reset = 1'b1;
    exp_q.push_back(6'b0);
    #1 e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL midreset_async got %b expected %b", obs, e); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_alu_forward();
    test_shadow();
    test_md(1'b1, 10);
    test_md(1'b0, 5);
    test_flush();
    test_reset_midstream();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational operand-use decoders.
- Tracks in-flight destination registers and their remaining Tnew across STAGES pipeline stages after ID, using a shift register.
- Compares those entries with the ID-stage operands' Tuse to produce the stall and the ID-stage forwarding selects.
- Also owns a mult/div busy countdown that stalls HI/LO instructions; sits beside the ID stage in the pipelined CPU.

Parameters:
STAGES, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB).
TNEW_W, 2, width of Tuse/Tnew fields.
REG_AW, 5, register address width.
MUL_CYCLES, 5, busy cycles after a mult/multu issue.
DIV_CYCLES, 10, busy cycles after a div/divu issue.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
id_valid  in  1  ID holds a real instruction.
id_rs_used  in  1  rs read by ID instruction.
id_rs_addr  in  REG_AW  rs number.
id_rs_tuse  in  TNEW_W  cycles until rs needed.
id_rt_used / id_rt_addr / id_rt_tuse  in  1/REG_AW/TNEW_W  same for rt.
id_wr_addr  in  REG_AW  destination, 0 = none.
id_tnew  in  TNEW_W  cycles after entering stage 1 until the result exists.
id_md_start  in  1  mult/multu/div/divu.
id_md_div  in  1  start is a divide.
id_md_access  in  1  mfhi/mflo/mthi/mtlo.
flush  in  1  exception/eret flush of stages 1..STAGES.
stall  out  1  hold PC/IF/ID, insert bubble into stage 1.
fwd_rs_sel  out  $clog2(STAGES+1)  0 = register file, k = stage k.
fwd_rt_sel  out  $clog2(STAGES+1)  same for rt.
md_busy  out  1  countdown non-zero.

Behaviour:
- State:
  - Per stage k: wr[k], tnew[k].
  - md_cnt, width $clog2(DIV_CYCLES+1).
- Reset (asynchronous): all wr=0, tnew=0, md_cnt=0.
  - This forces stall=0, fwd_*_sel=0, md_busy=0 regardless of ID inputs.
- Accept: accept = id_valid & ~stall & ~flush.
- Shift on every clock, since stages never stall:
  - Stage k+1 receives stage k with tnew saturating-decremented (0 stays 0).
  - The last stage's entry drops.
  - Stage 1 receives {id_wr_addr, id_tnew} if accept, otherwise the bubble {0,0}.
- Flush: the next edge loads every stage with a bubble and clears md_cnt. Flush has priority over accept.
- Match for operand x:
  - Requires x_used & x_addr!=0 & wr[k]==x_addr.
  - Only the smallest k (youngest) match counts. Older matches are shadowed.
- Data stall for x: the youngest match exists and tnew[k] > x_tuse.
- Forward select for x: k if the youngest match has tnew[k]==0, else 0.
  - Select 0 is also given when stalling or when there is no match.
- MD stall: (id_md_start | id_md_access) & md_busy.
- stall = id_valid & (rs data stall | rt data stall | MD stall).
  - Purely combinational from the current state and ID inputs; no registered latency.
- md_cnt update:
  - Loaded with DIV_CYCLES if id_md_div, else MUL_CYCLES, on accept & id_md_start.
  - Otherwise decremented while non-zero.
  - md_busy = (md_cnt != 0).
- $zero never creates a hazard or a forward.
- An instruction both reading and writing the same register compares against older stages only; its own entry is not yet present.
- Reset asserted mid-operation clears immediately, without waiting for the clock.

Decomposition:
- Shared package (CPU-wide, also used by the decoders): Tuse/Tnew encodings (TUSE_ID=0, TUSE_EX=1, TUSE_MEM=2) and the forward-select encodings.
- One sub-module: hazard_operand_check. It is instantiated twice (rs, rt) and does the youngest-match search plus the stall/select outputs over the STAGES entries.

Test Plan:
- Reset asserted mid-stream with id_valid=1 and a matching dependence present -> stall=0, sels=0, md_busy=0 immediately, before any clock edge.
- lw $8 (tnew=2) accepted, next ID is beq reading $8 (tuse=0):
  - stall=1 for 2 cycles.
  - In the third cycle, fwd_rs_sel=3 (tnew 0, stage WB), stall=0.
- addu $9 (tnew=1), then addu reading $9 as rt (tuse=1):
  - No stall.
  - fwd_rt_sel=0 in ID, because the youngest match has tnew=1, not 0.
- Shadowing: stage1 writes $5 with tnew=1 and stage2 writes $5 with tnew=0; ID reads rs=$5 with tuse=1 -> stall=0, fwd_rs_sel=0 (the stage1 match wins).
- div accepted, then mflo -> md_busy=1 and stall=1 for 10 cycles; mflo accepted on cycle 11.
  - The same sequence with mult -> mflo accepted on cycle 6.
- flush asserted while lw $8 is in stage1 and id_valid=1 with an $8 reader -> next cycle all stages are empty, stall=0, md_cnt=0, and the ID instruction is not entered.
